// File: rtl/imm_decode_stage.sv
// Immediate-generation stage: decodes RV32I/RV64I immediates and PC-relative targets,
// buffered by an output register plus one skid register with valid/ready handshakes.
module imm_decode_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_target,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    fmt_e            fmt;
    logic            illegal;
  } res_t;

  localparam bit IS64 = (XLEN == 64);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            shift_op;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] shamt_imm;
  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  res_t            dec_res;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign shift_op = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign i_imm    = sext32({{20{in_instr[31]}}, in_instr[31:20]});

  always_comb begin
    dec_imm   = '0;
    dec_fmt   = FMT_ILL;
    shamt_imm = '0;
    // Shamt width follows XLEN; funct7 selector bits never leak into the immediate
    shamt_imm[5:0] = IS64 ? in_instr[25:20] : {1'b0, in_instr[24:20]};
    case (opcode)
      7'b0110011: dec_fmt = FMT_R;
      7'b0111011: if (IS64) dec_fmt = FMT_R;
      7'b0010011: begin
        dec_fmt = FMT_I;
        dec_imm = shift_op ? shamt_imm : i_imm;
      end
      7'b0011011: if (IS64) begin
        dec_fmt = FMT_I;
        dec_imm = shift_op ? XLEN'(in_instr[24:20]) : i_imm;
      end
      7'b0000011, 7'b1100111, 7'b1110011: begin
        dec_fmt = FMT_I;
        dec_imm = i_imm;
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        dec_imm = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        dec_imm = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0});
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        dec_imm = sext32({in_instr[31:12], 12'b0});
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        dec_imm = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0});
      end
      default: dec_fmt = FMT_ILL;
    endcase
    dec_res.imm     = dec_imm;
    dec_res.target  = in_pc + dec_imm;
    dec_res.fmt     = dec_fmt;
    dec_res.illegal = (dec_fmt == FMT_ILL);
  end

  logic             or_valid_q, or_valid_d;
  logic             sr_valid_q, sr_valid_d;
  res_t             or_q, or_d;
  res_t             sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             xfer;

  assign in_ready = !sr_valid_q;
  assign accept   = in_valid && !sr_valid_q;
  assign xfer     = or_valid_q && out_ready;

  always_comb begin
    or_valid_d = or_valid_q;
    sr_valid_d = sr_valid_q;
    or_d       = or_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    if (xfer && or_q.illegal && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    if (flush) begin
      or_valid_d = 1'b0;
      sr_valid_d = 1'b0;
    end else if (xfer) begin
      // in_ready is low whenever SR is full, so SR refill and accept never coincide
      if (sr_valid_q) begin
        or_d       = sr_q;
        sr_valid_d = 1'b0;
      end else if (accept) begin
        or_d = dec_res;
      end else begin
        or_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!or_valid_q) begin
        or_d       = dec_res;
        or_valid_d = 1'b1;
      end else begin
        sr_d       = dec_res;
        sr_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_valid_q <= 1'b0;
      sr_valid_q <= 1'b0;
      or_q       <= '0;
      sr_q       <= '0;
      cnt_q      <= '0;
    end else begin
      or_valid_q <= or_valid_d;
      sr_valid_q <= sr_valid_d;
      or_q       <= or_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid   = or_valid_q;
  assign out_imm     = or_q.imm;
  assign out_target  = or_q.target;
  assign out_fmt     = or_q.fmt;
  assign out_illegal = or_q.illegal;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: a 64-bit and a 32-bit instance share stimulus;
// table vectors cover decode, hand sequences cover stall, flush and reset.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        out_ready;

  logic        rdy64, ov64, ill64;
  logic [63:0] imm64, tgt64;
  logic [2:0]  fmt64;
  logic [15:0] cnt64;

  logic        rdy32, ov32, ill32;
  logic [31:0] imm32, tgt32;
  logic [2:0]  fmt32;
  logic [1:0]  cnt32;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov64), .out_ready(out_ready),
    .out_imm(imm64), .out_target(tgt64), .out_fmt(fmt64), .out_illegal(ill64),
    .illegal_cnt(cnt64)
  );

  imm_decode_stage #(.XLEN(32), .CNT_W(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(ov32), .out_ready(out_ready),
    .out_imm(imm32), .out_target(tgt32), .out_fmt(fmt32), .out_illegal(ill32),
    .illegal_cnt(cnt32)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm64;
    logic [63:0] tgt64;
    logic [2:0]  fmt64;
    logic        ill64;
    logic [31:0] imm32;
    logic [31:0] tgt32;
    logic [2:0]  fmt32;
    logic        ill32;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc);
    in_valid = v;
    in_instr = ins;
    in_pc    = pc;
  endtask

  int exp_c64;
  int exp_c32;

  initial begin
    vecs[0]  = '{32'h0000003B, 64'h40, 64'h0, 64'h40, 3'd0, 1'b0, 32'h0, 32'h40, 3'd7, 1'b1};
    vecs[1]  = '{32'hFFF00093, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFF, 3'd1, 1'b0,
                 32'hFFFF_FFFF, 32'hFFF, 3'd1, 1'b0};
    vecs[2]  = '{32'hFE000EE3, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFC, 3'd3, 1'b0,
                 32'hFFFF_FFFC, 32'hFFC, 3'd3, 1'b0};
    vecs[3]  = '{32'h800002B7, 64'h0, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0,
                 32'h8000_0000, 32'h8000_0000, 3'd4, 1'b0};
    vecs[4]  = '{32'h0080006F, 64'h2000, 64'h8, 64'h2008, 3'd5, 1'b0, 32'h8, 32'h2008, 3'd5, 1'b0};
    vecs[5]  = '{32'h03F09093, 64'h100, 64'd63, 64'h13F, 3'd1, 1'b0, 32'd31, 32'h11F, 3'd1, 1'b0};
    vecs[6]  = '{32'h4010D093, 64'h0, 64'h1, 64'h1, 3'd1, 1'b0, 32'h1, 32'h1, 3'd1, 1'b0};
    vecs[7]  = '{32'hFE112E23, 64'h10, 64'hFFFF_FFFF_FFFF_FFFC, 64'hC, 3'd2, 1'b0,
                 32'hFFFF_FFFC, 32'hC, 3'd2, 1'b0};
    vecs[8]  = '{32'h002081B3, 64'h30, 64'h0, 64'h30, 3'd0, 1'b0, 32'h0, 32'h30, 3'd0, 1'b0};
    vecs[9]  = '{32'h0000007F, 64'h50, 64'h0, 64'h50, 3'd7, 1'b1, 32'h0, 32'h50, 3'd7, 1'b1};
    vecs[10] = '{32'hFFF0801B, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0,
                 32'h0, 32'h0, 3'd7, 1'b1};
    vecs[11] = '{32'h03F0909B, 64'h0, 64'd31, 64'd31, 3'd1, 1'b0, 32'h0, 32'h0, 3'd7, 1'b1};
    vecs[12] = '{32'h00001097, 64'h100, 64'h1000, 64'h1100, 3'd4, 1'b0, 32'h1000, 32'h1100, 3'd4, 1'b0};
    vecs[13] = '{32'h00C08067, 64'h0, 64'd12, 64'd12, 3'd1, 1'b0, 32'd12, 32'd12, 3'd1, 1'b0};
    vecs[14] = '{32'h80003083, 64'h1000, 64'hFFFF_FFFF_FFFF_F800, 64'h800, 3'd1, 1'b0,
                 32'hFFFF_F800, 32'h800, 3'd1, 1'b0};
    vecs[15] = '{32'h02000013, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'h10, 3'd1, 1'b0,
                 32'h20, 32'h10, 3'd1, 1'b0};

    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 64'h0);
    #12;
    chk("rst_out_valid", {ov64, ov32}, 2'b00);
    chk("rst_in_ready", {rdy64, rdy32}, 2'b11);
    chk("rst_imm64", imm64, 64'h0);
    chk("rst_tgt64", tgt64, 64'h0);
    chk("rst_fmt_ill", {fmt64, ill64, fmt32, ill32}, 8'h0);
    chk("rst_cnt", {cnt64, cnt32}, 18'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: one accept, one check cycle per vector, transfer on the following edge
    exp_c64 = 0;
    exp_c32 = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].instr, vecs[i].pc);
      @(negedge clk);
      drive(1'b0, 32'h0, 64'h0);
      chk("v_valid64", ov64, 1'b1);
      chk("v_imm64", imm64, vecs[i].imm64);
      chk("v_tgt64", tgt64, vecs[i].tgt64);
      chk("v_fmt64", fmt64, vecs[i].fmt64);
      chk("v_ill64", ill64, vecs[i].ill64);
      chk("v_valid32", ov32, 1'b1);
      chk("v_imm32", imm32, vecs[i].imm32);
      chk("v_tgt32", tgt32, vecs[i].tgt32);
      chk("v_fmt32", fmt32, vecs[i].fmt32);
      chk("v_ill32", ill32, vecs[i].ill32);
      chk("v_cnt64", cnt64, 64'(exp_c64));
      chk("v_cnt32", cnt32, 64'(exp_c32));
      if (vecs[i].ill64) exp_c64++;
      if (vecs[i].ill32 && exp_c32 < 3) exp_c32++;
    end
    @(negedge clk);
    chk("tbl_cnt64", cnt64, 64'(exp_c64));
    chk("tbl_cnt32_sat", cnt32, 64'(exp_c32));
    chk("tbl_idle", {ov64, ov32}, 2'b00);

    // Back-to-back acceptance with out_ready high
    drive(1'b1, 32'hFFF00093, 64'h1000);
    @(negedge clk);
    chk("pipe_a_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pipe_a_fmt", fmt64, 3'd1);
    drive(1'b1, 32'hFE000EE3, 64'h1000);
    @(negedge clk);
    drive(1'b0, 32'h0, 64'h0);
    chk("pipe_b_valid", ov64, 1'b1);
    chk("pipe_b_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("pipe_b_tgt", tgt64, 64'hFFC);
    chk("pipe_b_fmt", fmt64, 3'd3);
    @(negedge clk);
    chk("pipe_drain", ov64, 1'b0);

    // Stall: three offered, two taken, delivered in order
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 64'h0);
    @(negedge clk);
    chk("stall_rdy1", rdy64, 1'b1);
    chk("stall_a_imm", imm64, 64'd1);
    drive(1'b1, 32'h00200093, 64'h0);
    @(negedge clk);
    chk("stall_rdy_low", rdy64, 1'b0);
    chk("stall_hold_imm", imm64, 64'd1);
    drive(1'b1, 32'h00300093, 64'h0);
    @(negedge clk);
    chk("stall_rdy_still_low", rdy64, 1'b0);
    chk("stall_hold2", {ov64, imm64}, {1'b1, 64'd1});
    drive(1'b0, 32'h0, 64'h0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_b_out", {ov64, imm64}, {1'b1, 64'd2});
    chk("stall_rdy_back", rdy64, 1'b1);
    @(negedge clk);
    chk("stall_no_c", ov64, 1'b0);

    // Flush with both entries holding illegal items and an input offered
    out_ready = 1'b0;
    drive(1'b1, 32'h0000007F, 64'h0);
    @(negedge clk);
    drive(1'b1, 32'h0000007F, 64'h4);
    @(negedge clk);
    chk("fl_full", {ov64, rdy64}, 2'b10);
    flush = 1'b1;
    drive(1'b1, 32'h00100093, 64'h8);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0);
    chk("fl_empty", {ov64, rdy64}, 2'b01);
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl_no_out", ov64, 1'b0);
    chk("fl_cnt_same", cnt64, 64'(exp_c64));

    // Flush coinciding with an illegal-item transfer still counts it
    out_ready = 1'b0;
    drive(1'b1, 32'h0000007F, 64'h0);
    @(negedge clk);
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h00100093, 64'h0);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0);
    exp_c64++;
    chk("fl_xfer_cnt", cnt64, 64'(exp_c64));
    chk("fl_xfer_empty", ov64, 1'b0);

    // Asynchronous reset with both entries full
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 64'h1000);
    @(negedge clk);
    drive(1'b1, 32'h0000007F, 64'h2000);
    @(negedge clk);
    chk("mr_pre", {ov64, rdy64}, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", {ov64, ov32}, 2'b00);
    chk("mr_ready", {rdy64, rdy32}, 2'b11);
    chk("mr_imm", imm64, 64'h0);
    chk("mr_tgt", tgt64, 64'h0);
    chk("mr_fmt_ill", {fmt64, ill64}, 4'h0);
    chk("mr_cnt", cnt64, 64'h0);
    drive(1'b0, 32'h0, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mr_after", ov64, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Parametrised, pipelined immediate-generation stage between instruction fetch and execute. Accepts one instruction plus PC per valid/ready handshake and produces the sign- or zero-extended immediate, its format code, an illegal-opcode flag and the PC-relative target (PC + immediate). It covers every RV32I/RV64I base format (R, I, S, B, U, J), including shift-amount immediates. A two-entry skid buffer decouples the downstream stall from `in_ready` timing.

## Interface
- `XLEN`, default 64: datapath width; legal values are 32 and 64.
- `CNT_W`, default 16: width of the saturating illegal-instruction counter.

- `clk`  input  1  clock; all registers update on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `flush`  input  1  synchronous pipeline flush.
- `in_valid`  input  1  upstream instruction valid.
- `in_ready`  output  1  stage can accept an instruction.
- `in_instr`  input  32  instruction word.
- `in_pc`  input  XLEN  instruction address.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  downstream accepts the result.
- `out_imm`  output  XLEN  decoded immediate.
- `out_target`  output  XLEN  `in_pc + out_imm`, modulo 2^XLEN.
- `out_fmt`  output  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
- `out_illegal`  output  1  opcode not supported at this XLEN.
- `illegal_cnt`  output  CNT_W  count of illegal instructions delivered; saturates at all-ones.

## Operation
- **Format decode** uses `opcode = in_instr[6:0]`.
  - 0110011 and 0111011 → R, immediate 0.
  - 0010011, 0011011, 0000011, 1100111, 1110011 → I: sign-extend `instr[31:20]`.
  - 0100011 → S: sign-extend `{instr[31:25], instr[11:7]}`.
  - 1100011 → B: sign-extend `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.
  - 0110111 and 0010111 → U: sign-extend `{instr[31:12], 12'b0}` to XLEN.
  - 1101111 → J: sign-extend `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`.
  - Any other opcode → fmt 7, `out_illegal`=1, immediate 0.
- **Shift immediates.** For opcode 0010011 with funct3 001 or 101, the immediate is the zero-extended shamt:
  - XLEN=64: `instr[25:20]`.
  - XLEN=32: `instr[24:20]`.
  - Opcode 0011011 (W forms) with funct3 001 or 101 always uses `instr[24:20]`.
  - Bits 31:26 (e.g. the SRAI selector) never appear in the immediate.
- **XLEN=32.** Opcodes 0111011 and 0011011 are illegal.
- **Target.** `out_target = pc + imm` is computed for every format, including R and illegal; it wraps modulo 2^XLEN.
- **Buffering.** An output register (OR) plus one skid register (SR), each holding the full result.
  - Handshake: accept when `in_valid && in_ready`.
  - `in_ready = !sr_valid`, taken directly from a flop.
  - An accepted item loads OR if OR is empty or `out_ready` is high this cycle; otherwise it loads SR.
  - When SR is valid and OR drains (`out_ready`), SR moves to OR and SR empties.
- **Order.** Items are delivered strictly in acceptance order; none are lost or duplicated.
- **Illegal counter.** `illegal_cnt` increments on each output transfer (`out_valid && out_ready`) with `out_illegal`=1, and saturates at all-ones.
- **Flush.**
  - Next cycle: OR and SR are invalid.
  - Any input accepted in the flush cycle is discarded.
  - `illegal_cnt` is not cleared, but still counts a transfer that completes in the flush cycle.

## Timing
- **Reset** (asynchronous, while `rst_n`=0):
  - `out_valid`=0, `in_ready`=1.
  - `out_imm`=0, `out_target`=0, `out_fmt`=0, `out_illegal`=0, `illegal_cnt`=0.
- **Reset mid-operation.** All held items are dropped immediately.
- **Latency.** Acceptance at edge N gives `out_valid` during cycle N+1.
- **Throughput.** One item per cycle while `out_ready`=1.
- **Stable outputs.** While `out_valid && !out_ready`, all `out_*` fields hold stable.
- **Stall.**
  - First item accepted while stalled goes to SR; `in_ready` drops the following cycle.
  - `in_ready` rises again the cycle after SR drains.
- **Simultaneous accept and output transfer with SR empty:** the new item replaces OR; `out_valid` stays 1.
- **Simultaneous accept and output transfer with SR full:** cannot occur, because `in_ready`=0.
- **All outputs are registered.** There is no combinational path from inputs to `out_*` or to `in_ready`.

## Test plan
- **ADDI / BEQ / pipelining.** Drive `0xFFF00093` (ADDI x1,x0,-1), then `0xFE000EE3` (BEQ -4) at pc=0x1000 with `out_ready`=1. Expect, each one cycle after its accept:
  - ADDI: `out_imm`=0xFFFF_FFFF_FFFF_FFFF, fmt 1.
  - BEQ: `out_imm`=-4, `out_target`=0xFFC, fmt 3.
- **U / J formats, XLEN=64.**
  - LUI `0x800002B7` → `out_imm`=0xFFFF_FFFF_8000_0000.
  - JAL `0x0080006F` at pc=0x2000 → imm 8, target 0x2008, fmt 5.
- **Shift immediates, XLEN=64.**
  - SLLI `0x03F09093` → imm 63.
  - SRAI `0x4010D093` → imm 1, not 0x401.
- **XLEN=32 build.** `0x0000003B` → fmt 7, `out_illegal`=1, `illegal_cnt` 0→1 on transfer.
- **Stall and order.** Hold `out_ready`=0 and offer 3 back-to-back items. Expect:
  - 2 accepted; `in_ready`=0 from the cycle after the second accept.
  - On releasing `out_ready`, items appear in order; `in_ready` returns to 1.
- **Flush and reset.**
  - `flush` with both entries full and `in_valid`=1 → `out_valid`=0 next cycle, no output of the flushed items, `illegal_cnt` unchanged.
  - `rst_n`=0 mid-stream → all outputs at reset values immediately.
